// File: rtl/pipe_fifo_pkg.sv
// Shared definitions for the multi-channel pipe FIFO: direction encoding and count sizing.
// No logic here; nothing to stall.
package pipe_fifo_pkg;

  localparam logic DIR_H2U = 1'b0;
  localparam logic DIR_U2H = 1'b1;

  // Count needs one extra bit so a full channel (2^addr_width) is representable.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/pipe_fifo_multi_if.sv
// Host pipe-side bundle: channel selects, strobes and data; availability is combinational, read data registered.
// No backpressure: the host is expected to honour the available counts before strobing.
interface pipe_fifo_multi_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_WIDTH   = 2
);

  logic [CH_WIDTH-1:0]   ti_in_chan;
  logic                  ti_in_data_en;
  logic [DATA_WIDTH-1:0] ti_in_data;
  logic [15:0]           ti_in_available;
  logic [CH_WIDTH-1:0]   ti_out_chan;
  logic                  ti_out_data_en;
  logic [DATA_WIDTH-1:0] ti_out_data;
  logic [15:0]           ti_out_available;

  modport master (
    output ti_in_chan, ti_in_data_en, ti_in_data, ti_out_chan, ti_out_data_en,
    input  ti_in_available, ti_out_data, ti_out_available
  );

  modport slave (
    input  ti_in_chan, ti_in_data_en, ti_in_data, ti_out_chan, ti_out_data_en,
    output ti_in_available, ti_out_data, ti_out_available
  );

endinterface

// File: rtl/pipe_fifo_channel.sv
// One circular-buffer FIFO, one write and one read port; count updates one edge after a strobe.
// Full drops writes unless a read pops in the same cycle; empty reads yield 0. Flush overrides both ports.
module pipe_fifo_channel
  import pipe_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             wr_en,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             rd_en,
  output logic [DATA_WIDTH-1:0]            head_data,
  output logic [cnt_width(ADDR_WIDTH)-1:0] count,
  output logic                             ovf_pulse,
  output logic                             udf_pulse
);

  localparam int CW    = cnt_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  empty, full, rd_ok, wr_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_ok = rd_en & ~empty & ~flush;
  assign wr_ok = wr_en & (~full | rd_ok) & ~flush;

  assign ovf_pulse = wr_en & ~wr_ok & ~flush;
  assign udf_pulse = rd_en & empty & ~flush;
  // Empty reads present zero so the caller's output register can load head_data unconditionally.
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pipe_fifo_multi.sv
// CHANNELS independent pipe FIFOs with per-channel direction, sticky overflow/underflow flags.
// Write-to-count and read-to-data latency one cycle; full channels drop writes, empty reads return 0.
module pipe_fifo_multi
  import pipe_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int CHANNELS   = 4,
  parameter int CH_WIDTH   = 2
) (
  input  logic                                      ti_clk,
  input  logic                                      a_rst_n,
  input  logic                                      ti_rst_soft,
  input  logic [CHANNELS-1:0]                       cfg_dir,
  pipe_fifo_multi_if.slave                          ti,
  input  logic [CHANNELS-1:0]                       usr_wr_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0]            usr_wr_data,
  input  logic [CHANNELS-1:0]                       usr_rd_en,
  output logic [CHANNELS*DATA_WIDTH-1:0]            usr_rd_data,
  output logic [CHANNELS*cnt_width(ADDR_WIDTH)-1:0] usr_count,
  output logic [CHANNELS-1:0]                       stat_overflow,
  output logic [CHANNELS-1:0]                       stat_underflow
);

  localparam int CW    = cnt_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [CHANNELS-1:0]   dir_q, flush, host_wr, host_rd, ch_wr_en, ch_rd_en, ovf, udf;
  logic [DATA_WIDTH-1:0] ch_wr_data [CHANNELS];
  logic [DATA_WIDTH-1:0] head       [CHANNELS];
  logic [DATA_WIDTH-1:0] usr_rd_q   [CHANNELS];
  logic [CW-1:0]         cnt        [CHANNELS];
  logic [DATA_WIDTH-1:0] out_word, ti_out_q;
  logic                  out_ok;
  logic [CW-1:0]         in_free, out_cnt;

  always_ff @(posedge ti_clk or negedge a_rst_n) begin
    if (!a_rst_n) dir_q <= '0;
    else          dir_q <= cfg_dir;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign host_wr[c] = ti.ti_in_data_en  && (ti.ti_in_chan  == CH_WIDTH'(c));
    assign host_rd[c] = ti.ti_out_data_en && (ti.ti_out_chan == CH_WIDTH'(c));
    // A direction change empties the channel; soft reset empties every channel.
    assign flush[c]   = ti_rst_soft | (cfg_dir[c] ^ dir_q[c]);

    assign ch_wr_en[c]   = (cfg_dir[c] == DIR_U2H) ? usr_wr_en[c] : host_wr[c];
    assign ch_wr_data[c] = (cfg_dir[c] == DIR_U2H) ? usr_wr_data[c*DATA_WIDTH +: DATA_WIDTH]
                                                   : ti.ti_in_data;
    assign ch_rd_en[c]   = (cfg_dir[c] == DIR_U2H) ? host_rd[c] : usr_rd_en[c];

    pipe_fifo_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ch (
      .clk       (ti_clk),
      .rst_n     (a_rst_n),
      .flush     (flush[c]),
      .wr_en     (ch_wr_en[c]),
      .wr_data   (ch_wr_data[c]),
      .rd_en     (ch_rd_en[c]),
      .head_data (head[c]),
      .count     (cnt[c]),
      .ovf_pulse (ovf[c]),
      .udf_pulse (udf[c])
    );

    // User read register loads on every user strobe; a non-owned or flushed channel yields 0.
    always_ff @(posedge ti_clk or negedge a_rst_n) begin
      if (!a_rst_n)
        usr_rd_q[c] <= '0;
      else if (usr_rd_en[c] && !ti_rst_soft)
        usr_rd_q[c] <= (cfg_dir[c] == DIR_H2U && !flush[c]) ? head[c] : '0;
    end

    assign usr_rd_data[c*DATA_WIDTH +: DATA_WIDTH] = usr_rd_q[c];
    assign usr_count[c*CW +: CW]                    = cnt[c];
  end

  always_ff @(posedge ti_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      stat_overflow  <= '0;
      stat_underflow <= '0;
    end else if (ti_rst_soft) begin
      stat_overflow  <= '0;
      stat_underflow <= '0;
    end else begin
      stat_overflow  <= stat_overflow  | ovf;
      stat_underflow <= stat_underflow | udf;
    end
  end

  // Host-side selects; an out-of-range channel reads as no space and no data.
  always_comb begin
    out_word = '0;
    out_ok   = 1'b0;
    out_cnt  = '0;
    in_free  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ti.ti_out_chan == CH_WIDTH'(i)) begin
        out_word = head[i];
        out_ok   = (cfg_dir[i] == DIR_U2H) && !flush[i];
        out_cnt  = cnt[i];
      end
      if (ti.ti_in_chan == CH_WIDTH'(i))
        in_free = CW'(DEPTH) - cnt[i];
    end
  end

  always_ff @(posedge ti_clk or negedge a_rst_n) begin
    if (!a_rst_n)
      ti_out_q <= '0;
    else if (ti.ti_out_data_en && !ti_rst_soft)
      ti_out_q <= out_ok ? out_word : '0;
  end

  assign ti.ti_out_data      = ti_out_q;
  assign ti.ti_in_available  = 16'(in_free);
  assign ti.ti_out_available = 16'(out_cnt);

endmodule

// File: tb/tb_pipe_fifo_multi.sv
// Directed bench for pipe_fifo_multi at default parameters; expected values are hand-derived constants.
module tb_pipe_fifo_multi;

  logic        ti_clk = 1'b0;
  logic        a_rst_n = 1'b1;
  logic        ti_rst_soft;
  logic [3:0]  cfg_dir, usr_wr_en, usr_rd_en;
  logic [63:0] usr_wr_data, usr_rd_data;
  logic [19:0] usr_count;
  logic [3:0]  stat_overflow, stat_underflow;
  logic [63:0] w;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 ti_clk = ~ti_clk;

  pipe_fifo_multi_if #(.DATA_WIDTH(16), .CH_WIDTH(2)) ti_if ();

  pipe_fifo_multi #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (4),
    .CHANNELS   (4),
    .CH_WIDTH   (2)
  ) dut (
    .ti_clk         (ti_clk),
    .a_rst_n        (a_rst_n),
    .ti_rst_soft    (ti_rst_soft),
    .cfg_dir        (cfg_dir),
    .ti             (ti_if.slave),
    .usr_wr_en      (usr_wr_en),
    .usr_wr_data    (usr_wr_data),
    .usr_rd_en      (usr_rd_en),
    .usr_rd_data    (usr_rd_data),
    .usr_count      (usr_count),
    .stat_overflow  (stat_overflow),
    .stat_underflow (stat_underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic host_wr(input logic [15:0] d);
    ti_if.ti_in_data_en = 1'b1;
    ti_if.ti_in_data    = d;
    step();
    ti_if.ti_in_data_en = 1'b0;
  endtask

  initial begin
    ti_rst_soft = 1'b0;
    cfg_dir     = 4'b0000;
    usr_wr_en   = '0;
    usr_rd_en   = '0;
    usr_wr_data = '0;
    ti_if.ti_in_chan     = '0;
    ti_if.ti_in_data_en  = 1'b0;
    ti_if.ti_in_data     = '0;
    ti_if.ti_out_chan    = '0;
    ti_if.ti_out_data_en = 1'b0;
    #1 a_rst_n = 1'b0;
    #11;
    chk("rst_ti_out_data", 64'(ti_if.ti_out_data), 64'h0);
    chk("rst_usr_rd_data", usr_rd_data, 64'h0);
    chk("rst_usr_count", 64'(usr_count), 64'h0);
    chk("rst_flags", {56'h0, stat_overflow, stat_underflow}, 64'h0);
    chk("rst_in_avail", 64'(ti_if.ti_in_available), 64'd16);
    chk("rst_out_avail", 64'(ti_if.ti_out_available), 64'd0);
    a_rst_n = 1'b1;
    step();
    step();

    // Host -> user on channel 2
    ti_if.ti_in_chan = 2'd2;
    for (int i = 1; i <= 10; i++) host_wr(16'(i));
    chk("h2u_in_avail_6", 64'(ti_if.ti_in_available), 64'd6);
    chk("h2u_count_10", 64'(usr_count[10 +: 5]), 64'd10);
    for (int i = 1; i <= 10; i++) begin
      usr_rd_en = 4'b0100;
      step();
      usr_rd_en = 4'b0000;
      chk("h2u_rd_data", 64'(usr_rd_data[32 +: 16]), 64'(i));
    end
    chk("h2u_in_avail_16", 64'(ti_if.ti_in_available), 64'd16);

    // Overflow on channel 0, then full + simultaneous read/write
    ti_if.ti_in_chan = 2'd0;
    for (int i = 0; i < 17; i++) host_wr(16'h0100 + 16'(i));
    chk("ovf_flag", 64'(stat_overflow), 64'h1);
    chk("ovf_in_avail_0", 64'(ti_if.ti_in_available), 64'd0);
    usr_rd_en = 4'b0001;
    host_wr(16'h0200);
    usr_rd_en = 4'b0000;
    chk("full_rw_rd_data", 64'(usr_rd_data[0 +: 16]), 64'h0100);
    chk("full_rw_count", 64'(usr_count[0 +: 5]), 64'd16);
    chk("full_rw_in_avail", 64'(ti_if.ti_in_available), 64'd0);

    // User -> host on channel 1
    cfg_dir = 4'b0010;
    step();
    for (int i = 0; i < 16; i++) begin
      w = '0;
      w[16 +: 16] = 16'hA000 + 16'(i);
      usr_wr_data = w;
      usr_wr_en   = 4'b0010;
      step();
    end
    usr_wr_en = 4'b0000;
    ti_if.ti_out_chan = 2'd1;
    #1;
    chk("u2h_out_avail_16", 64'(ti_if.ti_out_available), 64'd16);
    for (int i = 0; i < 17; i++) begin
      ti_if.ti_out_data_en = 1'b1;
      step();
      ti_if.ti_out_data_en = 1'b0;
      chk("u2h_out_data", 64'(ti_if.ti_out_data), (i < 16) ? 64'(16'hA000 + 16'(i)) : 64'h0);
    end
    chk("u2h_udf_flag", 64'(stat_underflow), 64'h2);
    chk("u2h_out_avail_0", 64'(ti_if.ti_out_available), 64'd0);

    // Wrap-around on channel 3
    ti_if.ti_in_chan = 2'd3;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) host_wr(16'h3000 + 16'(r * 256 + i));
      for (int i = 0; i < 12; i++) begin
        usr_rd_en = 4'b1000;
        step();
        usr_rd_en = 4'b0000;
        chk("wrap_rd_data", 64'(usr_rd_data[48 +: 16]), 64'(16'h3000 + 16'(r * 256 + i)));
      end
    end
    chk("wrap_count_0", 64'(usr_count[15 +: 5]), 64'd0);

    // Soft reset in the middle of a write burst on channel 2
    ti_if.ti_in_chan = 2'd2;
    for (int i = 0; i < 3; i++) host_wr(16'h5550 + 16'(i));
    ti_rst_soft = 1'b1;
    host_wr(16'h5553);
    ti_rst_soft = 1'b0;
    chk("soft_counts", 64'(usr_count), 64'h0);
    chk("soft_flags", {56'h0, stat_overflow, stat_underflow}, 64'h0);
    chk("soft_in_avail", 64'(ti_if.ti_in_available), 64'd16);

    // Direction flip on channel 0 keeps flags
    usr_rd_en = 4'b0001;
    step();
    usr_rd_en = 4'b0000;
    chk("empty_rd_data", 64'(usr_rd_data[0 +: 16]), 64'h0);
    chk("empty_udf_flag", 64'(stat_underflow), 64'h1);
    ti_if.ti_in_chan = 2'd0;
    for (int i = 0; i < 5; i++) host_wr(16'h0700 + 16'(i));
    chk("flip_count_5", 64'(usr_count[0 +: 5]), 64'd5);
    cfg_dir = 4'b0011;
    step();
    step();
    chk("flip_count_0", 64'(usr_count[0 +: 5]), 64'd0);
    chk("flip_udf_kept", 64'(stat_underflow), 64'h1);
    chk("flip_ovf_kept", 64'(stat_overflow), 64'h0);

    // Async reset while the host is reading channel 1
    for (int i = 1; i <= 3; i++) begin
      w = '0;
      w[16 +: 16] = 16'hB000 + 16'(i);
      usr_wr_data = w;
      usr_wr_en   = 4'b0010;
      step();
    end
    usr_wr_en = 4'b0000;
    ti_if.ti_out_chan    = 2'd1;
    ti_if.ti_out_data_en = 1'b1;
    step();
    chk("arst_pre_rd1", 64'(ti_if.ti_out_data), 64'hB001);
    step();
    chk("arst_pre_rd2", 64'(ti_if.ti_out_data), 64'hB002);
    #2 a_rst_n = 1'b0;
    #1;
    chk("arst_out_data", 64'(ti_if.ti_out_data), 64'h0);
    chk("arst_out_avail", 64'(ti_if.ti_out_available), 64'd0);
    chk("arst_usr_rd_data", usr_rd_data, 64'h0);
    chk("arst_usr_count", 64'(usr_count), 64'h0);
    chk("arst_in_avail", 64'(ti_if.ti_in_available), 64'd16);
    ti_if.ti_out_data_en = 1'b0;
    a_rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
